// File: rtl/sipo_deserializer.sv
// MSB-first serial-to-parallel deserializer with frame realignment and a
// one-entry valid/ready output register that flags dropped words as overrun.
module sipo_deserializer #(
   parameter int WIDTH = 3
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       bit_valid,
   input  logic                       serial_in,
   input  logic                       frame_start,
   input  logic                       overrun_clr,
   output logic [WIDTH-1:0]           parallel_out,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       overrun,
   output logic [$clog2(WIDTH):0]     bit_count
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
   localparam logic [CW-1:0] ONE_CNT  = CW'(1);
   localparam logic [CW-1:0] ZERO_CNT = CW'(0);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_SHIFT = 1'b1;

   logic [0:0]       state_r;
   logic [0:0]       nxt_state_s;
   logic [CW-1:0]    count_r;
   logic [CW-1:0]    nxt_count_s;
   logic [WIDTH-2:0] shreg_r;
   logic [WIDTH-2:0] nxt_shreg_s;
   logic [WIDTH-1:0] word_s;
   logic             frame_done_s;
   logic             accept_s;

   assign word_s    = {shreg_r, serial_in};
   assign accept_s  = out_valid & out_ready;
   assign bit_count = count_r;

   // Input framing: next shift register, bit counter and state.
   always_comb begin
      nxt_state_s  = state_r;
      nxt_count_s  = count_r;
      nxt_shreg_s  = shreg_r;
      frame_done_s = 1'b0;
      if (frame_start) begin
         nxt_shreg_s = '0;
         if (bit_valid) begin
            nxt_shreg_s[0] = serial_in;
            nxt_count_s    = ONE_CNT;
            nxt_state_s    = S_SHIFT;
         end else begin
            nxt_count_s = ZERO_CNT;
            nxt_state_s = S_IDLE;
         end
      end else if (bit_valid) begin
         nxt_shreg_s = word_s[WIDTH-2:0];
         case (state_r)
            S_IDLE: begin
               nxt_count_s = ONE_CNT;
               nxt_state_s = S_SHIFT;
            end
            S_SHIFT: begin
               if (count_r == LAST_CNT) begin
                  nxt_count_s  = ZERO_CNT;
                  nxt_state_s  = S_IDLE;
                  frame_done_s = 1'b1;
               end else begin
                  nxt_count_s = count_r + ONE_CNT;
                  nxt_state_s = S_SHIFT;
               end
            end
            default: begin
               nxt_count_s = ZERO_CNT;
               nxt_state_s = S_IDLE;
            end
         endcase
      end else begin
         nxt_state_s = state_r;
      end
   end

   // Input framing registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= S_IDLE;
         count_r <= ZERO_CNT;
         shreg_r <= '0;
      end else begin
         state_r <= nxt_state_s;
         count_r <= nxt_count_s;
         shreg_r <= nxt_shreg_s;
      end
   end

   // Output holding register; a completing frame may refill it on the accept edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         parallel_out <= '0;
         out_valid    <= 1'b0;
      end else if (frame_done_s && (!out_valid || out_ready)) begin
         parallel_out <= word_s;
         out_valid    <= 1'b1;
      end else if (accept_s) begin
         out_valid <= 1'b0;
      end
   end

   // Sticky overrun: a new set beats a simultaneous clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overrun <= 1'b0;
      end else if (frame_done_s && out_valid && !out_ready) begin
         overrun <= 1'b1;
      end else if (overrun_clr) begin
         overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer (WIDTH=3) with hand-computed expectations.
module tb_sipo_deserializer;

   logic       clk = 1'b0;
   logic       reset;
   logic       bit_valid;
   logic       serial_in;
   logic       frame_start;
   logic       overrun_clr;
   logic [2:0] parallel_out;
   logic       out_valid;
   logic       out_ready;
   logic       overrun;
   logic [2:0] bit_count;

   int checks = 0;
   int errors = 0;

   sipo_deserializer #(.WIDTH(3)) dut (
      .clk          (clk),
      .reset        (reset),
      .bit_valid    (bit_valid),
      .serial_in    (serial_in),
      .frame_start  (frame_start),
      .overrun_clr  (overrun_clr),
      .parallel_out (parallel_out),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .overrun      (overrun),
      .bit_count    (bit_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One strobe on the next rising edge; returns at the following falling edge.
   task automatic strobe(input logic b, input logic fs);
      bit_valid   = 1'b1;
      serial_in   = b;
      frame_start = fs;
      @(negedge clk);
      bit_valid   = 1'b0;
      frame_start = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      reset = 1'b1; bit_valid = 1'b0; serial_in = 1'b0; frame_start = 1'b0;
      overrun_clr = 1'b0; out_ready = 1'b1;
      idle(2);
      reset = 1'b0;
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_count", 32'(bit_count), 32'd0);
      check("rst_word",  32'(parallel_out), 32'd0);
      check("rst_ovr",   32'(overrun), 32'd0);

      // 1. basic frame
      strobe(1'b1, 1'b0); strobe(1'b0, 1'b0);
      check("t1_count2", 32'(bit_count), 32'd2);
      check("t1_valid0", 32'(out_valid), 32'd0);
      strobe(1'b1, 1'b0);
      check("t1_valid", 32'(out_valid), 32'd1);
      check("t1_word",  32'(parallel_out), 32'b101);
      idle(1);
      check("t1_pulse", 32'(out_valid), 32'd0);
      check("t1_retain", 32'(parallel_out), 32'b101);

      // 2. gapped strobes
      strobe(1'b0, 1'b0);
      check("t2_c1", 32'(bit_count), 32'd1);
      idle(2);
      check("t2_hold", 32'(bit_count), 32'd1);
      strobe(1'b1, 1'b0);
      check("t2_c2", 32'(bit_count), 32'd2);
      idle(2);
      strobe(1'b1, 1'b0);
      check("t2_c0",   32'(bit_count), 32'd0);
      check("t2_valid", 32'(out_valid), 32'd1);
      check("t2_word", 32'(parallel_out), 32'b011);
      idle(1);

      // 3. backpressure / overrun
      out_ready = 1'b0;
      strobe(1'b1, 1'b0); strobe(1'b0, 1'b0); strobe(1'b1, 1'b0);
      check("t3_word1", 32'(parallel_out), 32'b101);
      check("t3_ovr0",  32'(overrun), 32'd0);
      strobe(1'b0, 1'b0); strobe(1'b1, 1'b0); strobe(1'b1, 1'b0);
      check("t3_keep",  32'(parallel_out), 32'b101);
      check("t3_ovr1",  32'(overrun), 32'd1);
      check("t3_valid", 32'(out_valid), 32'd1);
      overrun_clr = 1'b1;
      idle(1);
      overrun_clr = 1'b0;
      check("t3_clr",   32'(overrun), 32'd0);
      check("t3_held",  32'(parallel_out), 32'b101);
      out_ready = 1'b1;
      idle(1);
      check("t3_drain", 32'(out_valid), 32'd0);

      // 4. back-to-back accept
      strobe(1'b1, 1'b0); strobe(1'b0, 1'b0); strobe(1'b1, 1'b0);
      check("t4_w1", 32'(parallel_out), 32'b101);
      check("t4_v1", 32'(out_valid), 32'd1);
      strobe(1'b0, 1'b0);
      check("t4_gap", 32'(out_valid), 32'd0);
      strobe(1'b1, 1'b0); strobe(1'b1, 1'b0);
      check("t4_w2",  32'(parallel_out), 32'b011);
      check("t4_v2",  32'(out_valid), 32'd1);
      check("t4_ovr", 32'(overrun), 32'd0);
      idle(1);

      // 4b. accept and completion on the same edge: reload, no bubble
      out_ready = 1'b0;
      strobe(1'b1, 1'b1); strobe(1'b1, 1'b0); strobe(1'b0, 1'b0);
      check("t4b_w1", 32'(parallel_out), 32'b110);
      strobe(1'b0, 1'b0); strobe(1'b0, 1'b0);
      out_ready = 1'b1;
      strobe(1'b1, 1'b0);
      check("t4b_w2",  32'(parallel_out), 32'b001);
      check("t4b_v",   32'(out_valid), 32'd1);
      check("t4b_ovr", 32'(overrun), 32'd0);
      idle(1);
      check("t4b_done", 32'(out_valid), 32'd0);

      // 5. resync with frame_start
      strobe(1'b1, 1'b0); strobe(1'b1, 1'b0);
      check("t5_c2", 32'(bit_count), 32'd2);
      strobe(1'b0, 1'b1);
      check("t5_c1", 32'(bit_count), 32'd1);
      strobe(1'b1, 1'b0); strobe(1'b0, 1'b0);
      check("t5_word", 32'(parallel_out), 32'b010);
      check("t5_v",    32'(out_valid), 32'd1);
      check("t5_ovr",  32'(overrun), 32'd0);
      strobe(1'b1, 1'b0);
      frame_start = 1'b1;
      idle(1);
      frame_start = 1'b0;
      check("t5_fs_idle", 32'(bit_count), 32'd0);

      // 6. async reset mid-frame
      strobe(1'b1, 1'b0); strobe(1'b0, 1'b0);
      check("t6_pre", 32'(bit_count), 32'd2);
      #2 reset = 1'b1;
      #1;
      check("t6_count", 32'(bit_count), 32'd0);
      check("t6_word",  32'(parallel_out), 32'd0);
      check("t6_valid", 32'(out_valid), 32'd0);
      check("t6_ovr",   32'(overrun), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      strobe(1'b1, 1'b0); strobe(1'b0, 1'b0); strobe(1'b1, 1'b0);
      check("t6_word2", 32'(parallel_out), 32'b101);
      check("t6_v2",    32'(out_valid), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
